// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scheduler
// Purpose  : Round-robin sharing of the 8-bit seven-segment output among NREQ
//            requesters. Each grant owns the display for exactly HOLD_CYCLES
//            cycles; the winner's code is latched and decoded into segments.
// Options  : SEG_IDLE_DASH_EN - show a dash (8'h02) instead of blank when idle.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   code,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          seg,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] C_HOLD_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]   C_NREQ      = (PW+1)'(NREQ);
  localparam logic [PW-1:0] C_LAST      = PW'(NREQ - 1);

`ifdef SEG_IDLE_DASH_EN
  localparam logic [7:0] C_IDLE_PAT = 8'h02;
`else
  localparam logic [7:0] C_IDLE_PAT = 8'h00;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [7:0]      r_seg, w_seg_nxt;
  logic            r_busy, w_busy_nxt;

  logic [PW-1:0]   w_owner_inc;
  logic [PW-1:0]   w_base;
  logic [PW:0]     w_pos;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [7:0]      w_win_code;
  logic [NREQ-1:0] w_win_gnt;

  // Display code to segment bits; unknown codes blank the display
  function automatic logic [7:0] f_decode(input logic [7:0] c);
    logic [7:0] v;
    case (c)
      8'h00:   v = 8'hFD;
      8'h01:   v = 8'hC1;
      8'h02:   v = 8'h6F;
      8'h03:   v = 8'hE7;
      8'h04:   v = 8'hD3;
      8'h05:   v = 8'hB7;
      8'h06:   v = 8'hBF;
      8'h07:   v = 8'hE1;
      8'h08:   v = 8'hFF;
      8'h09:   v = 8'hF7;
      default: v = (c[7:3] == 5'b11110) ? (8'h80 >> c[2:0]) : 8'h00;
    endcase
    return v;
  endfunction

  // At hold expiry the search starts just past the current owner, making it lowest priority
  assign w_owner_inc = (r_owner == C_LAST) ? '0 : r_owner + 1'b1;
  assign w_base      = (r_state == S_HOLD) ? w_owner_inc : r_rr_ptr;

  // Rotating priority search: first requester at or after w_base, wrapping mod NREQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, w_base} + (PW+1)'(k);
      if (w_pos >= C_NREQ) w_pos = w_pos - C_NREQ;
      if (!w_found && req[w_pos[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[PW-1:0];
      end
    end
  end

  // Select the winner's code and build its one-hot grant
  always_comb begin
    w_win_code = '0;
    w_win_gnt  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win == PW'(j)) begin
        w_win_code   = code[8*j +: 8];
        w_win_gnt[j] = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate when idle or when a hold expires, otherwise freeze outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gnt_nxt      = r_gnt;
    w_seg_nxt      = r_seg;
    w_busy_nxt     = r_busy;
    if (r_state == S_HOLD && r_hold_cnt != '0) begin
      w_hold_cnt_nxt = r_hold_cnt - 1'b1;
    end else begin
      if (r_state == S_HOLD) w_rr_ptr_nxt = w_owner_inc;
      if (w_found) begin
        w_state_nxt    = S_HOLD;
        w_owner_nxt    = w_win;
        w_hold_cnt_nxt = C_HOLD_INIT;
        w_gnt_nxt      = w_win_gnt;
        w_seg_nxt      = f_decode(w_win_code);
        w_busy_nxt     = 1'b1;
      end else begin
        w_state_nxt    = S_IDLE;
        w_gnt_nxt      = '0;
        w_seg_nxt      = C_IDLE_PAT;
        w_busy_nxt     = 1'b0;
      end
    end
  end

  // State and output registers; reset drops any grant immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_seg      <= C_IDLE_PAT;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_seg      <= w_seg_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign seg  = r_seg;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scheduler
// Purpose  : Self-checking bench for seg_display_scheduler. Two instances
//            (HOLD_CYCLES=4 and HOLD_CYCLES=1) share stimulus and are each
//            compared every cycle against a behavioural display-sharing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

  localparam int N = 4;

`ifdef SEG_IDLE_DASH_EN
  localparam logic [7:0] IDLE_PAT = 8'h02;
`else
  localparam logic [7:0] IDLE_PAT = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [31:0]  code;
  logic [N-1:0] gnt4, gnt1;
  logic [7:0]   seg4, seg1;
  logic         busy4, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the display, how many cycles remain, where the search starts
  int         m_owner [2];
  int         m_left  [2];
  int         m_ptr   [2];
  logic [7:0] m_seg   [2];
  int         hold_of [2] = '{4, 1};
  logic [7:0] dec_tbl [10] = '{8'hFD, 8'hC1, 8'h6F, 8'hE7, 8'hD3,
                               8'hB7, 8'hBF, 8'hE1, 8'hFF, 8'hF7};

  seg_display_scheduler #(.NREQ(N), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .code(code),
    .gnt(gnt4), .seg(seg4), .busy(busy4)
  );

  seg_display_scheduler #(.NREQ(N), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .code(code),
    .gnt(gnt1), .seg(seg1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_decode(input logic [7:0] c);
    int v;
    if (c <= 8'h09) return dec_tbl[c];
    if (c >= 8'hF0 && c <= 8'hF7) begin
      v = 1 << (7 - int'(c - 8'hF0));
      return 8'(v);
    end
    return 8'h00;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int m);
    if (m_owner[m] < 0) return '0;
    return N'(1 << m_owner[m]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_left[m]  = 0;
      m_ptr[m]   = 0;
      m_seg[m]   = IDLE_PAT;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    int found;
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (m_owner[m] >= 0 && m_left[m] > 1) begin
        m_left[m] = m_left[m] - 1;
      end else begin
        if (m_owner[m] >= 0) m_ptr[m] = (m_owner[m] + 1) % N;
        found = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr[m] + k) % N;
          if (found < 0 && req[idx]) found = idx;
        end
        if (found >= 0) begin
          m_owner[m] = found;
          m_left[m]  = hold_of[m];
          m_seg[m]   = ref_decode(code[8*found +: 8]);
        end else begin
          m_owner[m] = -1;
          m_left[m]  = 0;
          m_seg[m]   = IDLE_PAT;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("gnt_h4",  32'(gnt4),  32'(exp_gnt(0)));
    chk("seg_h4",  32'(seg4),  32'(m_seg[0]));
    chk("busy_h4", 32'(busy4), 32'(m_owner[0] >= 0));
    chk("gnt_h1",  32'(gnt1),  32'(exp_gnt(1)));
    chk("seg_h1",  32'(seg1),  32'(m_seg[1]));
    chk("busy_h1", 32'(busy1), 32'(m_owner[1] >= 0));
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 2))
      0:       return 8'($urandom_range(0, 9));
      1:       return 8'h F0 + 8'($urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst  = 1'b1;
    req  = '0;
    code = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_gnt",  32'(gnt4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    chk("rst_seg",  32'(seg4), 32'(IDLE_PAT));

    // Single requester, request dropped during the hold
    code = 32'h0000_0003;
    req  = 4'b0001;
    step();
    chk("t2_gnt", 32'(gnt4), 32'h1);
    chk("t2_seg", 32'(seg4), 32'hE7);
    req = 4'b0000;
    step(); step(); step();
    chk("t2_held", 32'(gnt4), 32'h1);
    step();
    chk("t2_rel_gnt", 32'(gnt4), 32'h0);
    chk("t2_rel_seg", 32'(seg4), 32'(IDLE_PAT));

    // Two contenders alternate with no idle gap
    code = {rand_code(), rand_code(), rand_code(), rand_code()};
    req  = 4'b1010;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) chk("t3_first",  32'(gnt4), 32'h2);
      if (i == 4) chk("t3_second", 32'(gnt4), 32'h8);
      if (i == 8) chk("t3_third",  32'(gnt4), 32'h2);
    end
    req = '0;
    for (int i = 0; i < 5; i++) step();

    // Single-segment code, code change ignored mid-hold, unknown code
    code = 32'h0000_00F2;
    req  = 4'b0001;
    step();
    chk("t4_f2", 32'(seg4), 32'h20);
    code = 32'h0000_0005;
    step();
    chk("t4_frozen", 32'(seg4), 32'h20);
    req = '0;
    for (int i = 0; i < 4; i++) step();
    code = 32'h0000_000A;
    req  = 4'b0001;
    step();
    chk("t4_0a_seg",  32'(seg4), 32'h00);
    chk("t4_0a_busy", 32'(busy4), 32'h1);
    req = '0;
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset during the second hold cycle of requester 2
    code = {rand_code(), rand_code(), rand_code(), rand_code()};
    req  = 4'b0100;
    step();
    step();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("t5_gnt",  32'(gnt4), 32'h0);
    chk("t5_seg",  32'(seg4), 32'(IDLE_PAT));
    chk("t5_busy", 32'(busy4), 32'h0);
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("t5_restart", 32'(gnt4), 32'h1);
    req = '0;
    for (int i = 0; i < 5; i++) step();

    // Single-cycle hold rotates every cycle
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    req = 4'b0111;
    step();
    chk("t6_r0", 32'(gnt1), 32'h1);
    step();
    chk("t6_r1", 32'(gnt1), 32'h2);
    step();
    chk("t6_r2", 32'(gnt1), 32'h4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int b = 0; b < N; b++) code[8*b +: 8] = rand_code();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
